// File: rtl/uart_receiver.sv
// uart_receiver: 8-bit LSB-first UART receiver with a two-flop rx synchronizer.
// Optional even-parity support is compiled in when UART_RX_PARITY_EN is defined;
// without it the frame is start + 8 data + stop (10 bits) and there is no parity_error port.
module uart_receiver #(
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int BAUD_RATE       = 115200
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] char_data,
    output logic       char_ready,
    output logic       framing_error
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_error
`endif
);

    localparam int CLKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_IDLE
    } state_t;

    state_t           state_q, state_d;
    logic             rx_meta_q, rx_meta_d;
    logic             rx_sync_q, rx_sync_d;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       char_data_q, char_data_d;
    logic             char_ready_q, char_ready_d;
    logic             framing_error_q, framing_error_d;
`ifdef UART_RX_PARITY_EN
    logic             parity_bit_q, parity_bit_d;
    logic             parity_error_q, parity_error_d;
`endif

    // Register all state; reset idles the line high so no false start edge is seen.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            rx_meta_q       <= 1'b1;
            rx_sync_q       <= 1'b1;
            clk_cnt_q       <= '0;
            bit_cnt_q       <= '0;
            shift_q         <= '0;
            char_data_q     <= '0;
            char_ready_q    <= 1'b0;
            framing_error_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bit_q    <= 1'b0;
            parity_error_q  <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            rx_meta_q       <= rx_meta_d;
            rx_sync_q       <= rx_sync_d;
            clk_cnt_q       <= clk_cnt_d;
            bit_cnt_q       <= bit_cnt_d;
            shift_q         <= shift_d;
            char_data_q     <= char_data_d;
            char_ready_q    <= char_ready_d;
            framing_error_q <= framing_error_d;
`ifdef UART_RX_PARITY_EN
            parity_bit_q    <= parity_bit_d;
            parity_error_q  <= parity_error_d;
`endif
        end
    end

    // Frame FSM: find the start edge, confirm it mid-bit, then sample each bit at its centre.
    always_comb begin
        rx_meta_d       = rx;
        rx_sync_d       = rx_meta_q;
        state_d         = state_q;
        clk_cnt_d       = clk_cnt_q;
        bit_cnt_d       = bit_cnt_q;
        shift_d         = shift_q;
        char_data_d     = char_data_q;
        char_ready_d    = 1'b0;
        framing_error_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_bit_d    = parity_bit_q;
        parity_error_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                clk_cnt_d = '0;
                bit_cnt_d = '0;
                if (!rx_sync_q) begin
                    state_d = START;
                end
            end
            START: begin
                if (clk_cnt_q == HALF_LAST) begin
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = rx_sync_q ? IDLE : DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_sync_q, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d    = '0;
                    parity_bit_d = rx_sync_q;
                    state_d      = STOP;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
`endif
            STOP: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = '0;
                    if (rx_sync_q) begin
                        state_d = IDLE;
`ifdef UART_RX_PARITY_EN
                        if (^{shift_q, parity_bit_q}) begin
                            parity_error_d = 1'b1;
                        end else begin
                            char_data_d  = shift_q;
                            char_ready_d = 1'b1;
                        end
`else
                        char_data_d  = shift_q;
                        char_ready_d = 1'b1;
`endif
                    end else begin
                        framing_error_d = 1'b1;
                        state_d         = WAIT_IDLE;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            WAIT_IDLE: begin
                if (rx_sync_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign char_data     = char_data_q;
    assign char_ready    = char_ready_q;
    assign framing_error = framing_error_q;
`ifdef UART_RX_PARITY_EN
    assign parity_error  = parity_error_q;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed and randomized serial frames for uart_receiver, checked
// against a byte-level model of what each frame should produce.
// Define UART_RX_PARITY_EN to also exercise the even-parity build.
module tb_uart_receiver;

    localparam int CLK_HZ = 50000000;
    localparam int BAUD   = 115200;
    localparam int CPB    = CLK_HZ / BAUD;
    localparam int EXP_LATENCY = (19 * CPB) / 2 + 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       rx    = 1'b1;
    logic [7:0] char_data;
    logic       char_ready;
    logic       framing_error;
`ifdef UART_RX_PARITY_EN
    logic       parity_error;
    logic       flip_parity = 1'b0;
    int         pe_count = 0;
    int         exp_pe = 0;
    logic       prev_pe = 1'b0;
`endif

    uart_receiver #(
        .CLOCK_FREQUENCY(CLK_HZ),
        .BAUD_RATE(BAUD)
    ) dut (
        .clock(clock),
        .reset(reset),
        .rx(rx),
        .char_data(char_data),
        .char_ready(char_ready),
        .framing_error(framing_error)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_error(parity_error)
`endif
    );

    // 50 MHz clock
    always #10 clock = ~clock;

    int cyc = 0;
    // Free-running cycle count used to time the first strobe
    always @(posedge clock) cyc <= cyc + 1;

    logic [7:0] ready_q[$];
    int         ready_cycle = 0;
    int         fe_count = 0;
    int         width_viol = 0;
    int         excl_viol = 0;
    logic       prev_ready = 1'b0;
    logic       prev_fe = 1'b0;

    // Observe DUT strobes on the falling edge, away from the active edge
    always @(negedge clock) begin
        if (char_ready) begin
            ready_q.push_back(char_data);
            ready_cycle = cyc;
        end
        if (framing_error) fe_count++;
        if ((char_ready && prev_ready) || (framing_error && prev_fe)) width_viol++;
        if (char_ready && framing_error) excl_viol++;
        prev_ready = char_ready;
        prev_fe    = framing_error;
`ifdef UART_RX_PARITY_EN
        if (parity_error) pe_count++;
        if (parity_error && prev_pe) width_viol++;
        if (parity_error && (char_ready || framing_error)) excl_viol++;
        prev_pe = parity_error;
`endif
    end

    logic [7:0] exp_q[$];
    logic [7:0] exp_last = 8'h00;
    int         exp_fe = 0;
    int         start_cycle = 0;
    int         check_count = 0;
    int         pass_count = 0;
    int         fail_count = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else begin
            fail_count++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one frame starting at a falling edge; returns with rx still at the stop level.
    task automatic applyStimulus(input logic [7:0] data, input logic stop_bit);
        rx = 1'b0;
        start_cycle = cyc;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            repeat (CPB) @(negedge clock);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^data) ^ flip_parity;
        repeat (CPB) @(negedge clock);
`endif
        rx = stop_bit;
        repeat (CPB) @(negedge clock);
        if (!stop_bit) exp_fe++;
`ifdef UART_RX_PARITY_EN
        else if (flip_parity) exp_pe++;
`endif
        else begin
            exp_q.push_back(data);
            exp_last = data;
        end
    endtask

    task automatic idleLine(input int cycles);
        rx = 1'b1;
        repeat (cycles) @(negedge clock);
    endtask

    task automatic drainAndCompare(input string tag);
        checkOutput({tag, " strobe count"}, ready_q.size(), exp_q.size());
        while (ready_q.size() > 0 && exp_q.size() > 0)
            checkOutput({tag, " byte"}, ready_q.pop_front(), exp_q.pop_front());
        ready_q.delete();
        exp_q.delete();
    endtask

    logic [7:0] msg [4] = '{8'h53, 8'h33, 8'h0D, 8'h0A};
    logic [7:0] rnd_data;
    logic       rnd_stop;
    int         latency;

    initial begin
        $display("[TB] reset");
        reset = 1'b1;
        repeat (5) @(negedge clock);
        checkOutput("reset char_data", char_data, 8'h00);
        checkOutput("reset char_ready", char_ready, 1'b0);
        checkOutput("reset framing_error", framing_error, 1'b0);
`ifdef UART_RX_PARITY_EN
        checkOutput("reset parity_error", parity_error, 1'b0);
`endif
        reset = 1'b0;
        idleLine(CPB);

        $display("[TB] single 0x53");
        applyStimulus(8'h53, 1'b1);
        idleLine(CPB);
        latency = ready_cycle - start_cycle;
        checkOutput("0x53 latency in window",
                    (latency >= EXP_LATENCY - 3) && (latency <= EXP_LATENCY + 3), 1'b1);
        drainAndCompare("0x53");
        checkOutput("0x53 char_data held", char_data, exp_last);

        $display("[TB] back-to-back S3 CR LF");
        for (int i = 0; i < 4; i++) applyStimulus(msg[i], 1'b1);
        idleLine(CPB);
        drainAndCompare("S3CRLF");
        checkOutput("S3CRLF char_data", char_data, 8'h0A);

        $display("[TB] framing error on 0x41");
        applyStimulus(8'h41, 1'b0);
        repeat (3 * CPB) @(negedge clock);
        checkOutput("framing count while low", fe_count, exp_fe);
        idleLine(2 * CPB);
        checkOutput("framing count after high", fe_count, exp_fe);
        drainAndCompare("framing");
        checkOutput("framing char_data kept", char_data, exp_last);

        $display("[TB] start glitch then 0x41");
        rx = 1'b0;
        repeat (100) @(negedge clock);
        idleLine(2 * CPB);
        drainAndCompare("glitch");
        checkOutput("glitch framing count", fe_count, exp_fe);
        applyStimulus(8'h41, 1'b1);
        idleLine(CPB);
        drainAndCompare("after glitch");
        checkOutput("after glitch char_data", char_data, 8'h41);

        $display("[TB] reset during 0x7E, then 0x30");
        rx = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 5; i++) begin
            rx = (i == 0) ? 1'b0 : 1'b1;
            repeat ((i == 4) ? CPB / 2 : CPB) @(negedge clock);
        end
        reset = 1'b1;
        exp_last = 8'h00;
        repeat (10) @(negedge clock);
        reset = 1'b0;
        idleLine(3 * CPB);
        checkOutput("mid-frame reset char_data", char_data, exp_last);
        drainAndCompare("mid-frame reset");
        applyStimulus(8'h30, 1'b1);
        idleLine(CPB);
        drainAndCompare("0x30");
        checkOutput("0x30 char_data", char_data, 8'h30);

        $display("[TB] random frames");
        for (int n = 0; n < 5; n++) begin
            rnd_data = 8'($urandom_range(0, 255));
            rnd_stop = ($urandom_range(0, 3) != 0);
            applyStimulus(rnd_data, rnd_stop);
            if (!rnd_stop) begin
                repeat ($urandom_range(10, 300)) @(negedge clock);
                idleLine(CPB);
            end
        end
        idleLine(CPB);
        drainAndCompare("random");
        checkOutput("random framing count", fe_count, exp_fe);
        checkOutput("random char_data", char_data, exp_last);

`ifdef UART_RX_PARITY_EN
        $display("[TB] parity");
        flip_parity = 1'b1;
        applyStimulus(8'h53, 1'b1);
        flip_parity = 1'b0;
        idleLine(CPB);
        checkOutput("parity error count", pe_count, exp_pe);
        drainAndCompare("bad parity");
        checkOutput("bad parity char_data kept", char_data, exp_last);
        applyStimulus(8'h53, 1'b1);
        idleLine(CPB);
        drainAndCompare("good parity");
        checkOutput("good parity error count", pe_count, exp_pe);
`endif

        checkOutput("strobe width violations", width_viol, 0);
        checkOutput("strobe exclusivity violations", excl_viol, 0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter CLOCK_FREQUENCY, default 50000000, clock rate in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, serial bit rate.
REQ-003 SHALL port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL port reset  input  1  reset is asynchronous and active-high.
REQ-005 SHALL port rx  input  1  asynchronous serial line, idle high, 8 data bits LSB first.
REQ-006 SHALL port char_data  output  8  last correctly received byte; feeds the S-record parser char_data.
REQ-007 SHALL port char_ready  output  1  one-cycle strobe, char_data valid; feeds the parser char_ready.
REQ-008 SHALL port framing_error  output  1  one-cycle pulse, stop bit sampled low.
REQ-009 SHALL port parity_error  output  1  one-cycle pulse, parity mismatch; present only under UART_RX_PARITY_EN.

Function
REQ-010 SHALL use CLKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE (integer division); values below 8 are unsupported.
REQ-011 SHALL pass rx through a two-flop synchronizer; all decisions use the synchronized value.
REQ-012 SHALL implement states IDLE, START, DATA, PARITY (macro only), STOP and WAIT_IDLE.
REQ-013 IDLE: synchronized rx = 0 -> START, bit counter cleared.
REQ-014 START: after CLKS_PER_BIT/2 clocks, rx = 0 -> DATA with counter cleared; rx = 1 -> IDLE, glitch ignored, no output.
REQ-015 DATA: sample rx every CLKS_PER_BIT clocks and shift it in LSB first; after the 8th sample -> PARITY if compiled in, else STOP.
REQ-016 STOP: sample rx after CLKS_PER_BIT clocks. rx = 1 -> load char_data, pulse char_ready next cycle, -> IDLE. rx = 0 -> pulse framing_error, keep char_data, -> WAIT_IDLE.
REQ-017 WAIT_IDLE: stay until synchronized rx = 1, then -> IDLE; break conditions produce no further strobes.
REQ-018 char_ready, framing_error and parity_error SHALL each be high for exactly one clock per event and are mutually exclusive.
REQ-019 char_data SHALL hold its value between strobes; a failed frame never modifies it.
REQ-020 Back-to-back frames (one stop bit, no idle gap) SHALL each be received; the start-edge search resumes the cycle after the stop sample.
REQ-021 Bit and sample counters SHALL be wide enough for CLKS_PER_BIT without wrap-around.

Reset
REQ-022 Reset SHALL force state IDLE, both synchronizer flops to 1, counters and shift register to 0.
REQ-023 Reset SHALL force char_data = 0x00, char_ready = 0, framing_error = 0 and parity_error = 0.
REQ-024 Reset asserted mid-frame SHALL discard the partial byte; after release, reception restarts on the next falling edge.

Configuration
REQ-025 With macro UART_RX_PARITY_EN defined: an even-parity bit follows data bit 7 and is sampled in PARITY, then -> STOP.
REQ-026 With UART_RX_PARITY_EN defined, a valid stop bit with a parity mismatch SHALL pulse parity_error instead of char_ready and leave char_data unchanged.
REQ-027 Without UART_RX_PARITY_EN: no PARITY state, no parity_error port, and the frame is 10 bits.

Verification (50 MHz, 115200 baud, CLKS_PER_BIT = 434)
REQ-028 Frame 0x53 ('S') -> char_ready for one cycle with char_data = 0x53, about 9.5 bit times plus 2 clocks after the start edge.
REQ-029 Back-to-back "S3\r\n" (0x53 0x33 0x0D 0x0A) with no gaps -> four char_ready pulses, in order, with those values.
REQ-030 rx low for 100 clocks, then high -> no strobe of any kind; a following 0x41 is received correctly.
REQ-031 0x41 with the stop bit held low -> one framing_error pulse, no char_ready, char_data unchanged; no output until rx returns high.
REQ-032 Reset pulse during data bit 4 of 0x7E, then a clean 0x30 -> only char_data = 0x30 is strobed.
REQ-033 Under UART_RX_PARITY_EN: 0x53 with parity bit 1 (wrong) -> parity_error pulse, no char_ready; with parity bit 0 -> char_ready with 0x53.
